// File: rtl/spi_ptos_tx.sv
// Parallel-to-serial SPI transmitter: accepts a word on valid/ready and shifts it out MSB-first
// with a generated sclk (idle low), active-low cs_n and a per-bit bit_valid strobe.
module spi_ptos_tx #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             mosi,
    output logic             sclk,
    output logic             cs_n,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned DW = $clog2(CLK_DIV) + 1;
    localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StLow, StHigh, StTail, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             div_end;
    logic             in_frame;

    assign div_end = (div_cnt_q == DivLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    shift_d   = data_in;
                    bit_cnt_d = BitLast;
                    div_cnt_d = '0;
                    state_d   = StLow;
                end
            end
            StLow: begin
                if (div_end) begin
                    div_cnt_d = '0;
                    state_d   = StHigh;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (div_end) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q == '0) begin
                        state_d = StTail;
                    end else begin
                        // Shift only at the end of HIGH so mosi moves on the sclk falling edge.
                        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        state_d   = StLow;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StTail: begin
                if (div_end) begin
                    div_cnt_d = '0;
                    state_d   = StDone;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode state directly, so reset forces them idle without waiting for a clock.
    assign in_frame  = (state_q == StLow) || (state_q == StHigh) || (state_q == StTail);
    assign ready     = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign cs_n      = ~in_frame;
    assign sclk      = (state_q == StHigh);
    assign mosi      = in_frame & shift_q[WIDTH-1];
    assign bit_valid = (state_q == StLow) && div_end;
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_spi_ptos_tx.sv
// Directed bench for spi_ptos_tx: three instances cover WIDTH/CLK_DIV = 10/2, 10/1 and 2/3.
module tb_spi_ptos_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din [3] = '{16'h0, 16'h0, 16'h0};
    logic [2:0]  vld = 3'b000;
    wire  [2:0]  rdy, mosi_v, sclk_v, csn_v, bv_v, busy_v, done_v;

    always #5 clk = ~clk;

    spi_ptos_tx #(.WIDTH(10), .CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(din[0][9:0]), .valid(vld[0]), .ready(rdy[0]),
        .mosi(mosi_v[0]), .sclk(sclk_v[0]), .cs_n(csn_v[0]), .bit_valid(bv_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );
    spi_ptos_tx #(.WIDTH(10), .CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(din[1][9:0]), .valid(vld[1]), .ready(rdy[1]),
        .mosi(mosi_v[1]), .sclk(sclk_v[1]), .cs_n(csn_v[1]), .bit_valid(bv_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );
    spi_ptos_tx #(.WIDTH(2), .CLK_DIV(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(din[2][1:0]), .valid(vld[2]), .ready(rdy[2]),
        .mosi(mosi_v[2]), .sclk(sclk_v[2]), .cs_n(csn_v[2]), .bit_valid(bv_v[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state, written only by the monitor process.
    int          cs_low [3] = '{0, 0, 0};
    int          bvc    [3] = '{0, 0, 0};
    int          donec  [3] = '{0, 0, 0};
    int          rises  [3] = '{0, 0, 0};
    int          hirun  [3] = '{0, 0, 0};
    int          maxhi  [3] = '{0, 0, 0};
    int          hicnt  [3] = '{0, 0, 0};
    int          gap    [3] = '{0, 0, 0};
    int          rdy_bad[3] = '{0, 0, 0};
    logic [31:0] rx     [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] rbits  [3] = '{32'h0, 32'h0, 32'h0};
    logic [2:0]  prev_sclk = 3'b000;
    logic [2:0]  prev_csn  = 3'b111;

    int s_cs, s_bv, s_done, s_rise;

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!csn_v[i]) cs_low[i]++;
            if (bv_v[i]) begin
                bvc[i]++;
                rx[i] = {rx[i][30:0], mosi_v[i]};
            end
            if (done_v[i]) donec[i]++;
            if (sclk_v[i] && !prev_sclk[i]) begin
                rises[i]++;
                rbits[i] = {rbits[i][30:0], mosi_v[i]};
            end
            if (sclk_v[i]) begin
                hirun[i]++;
                if (hirun[i] > maxhi[i]) maxhi[i] = hirun[i];
            end else begin
                hirun[i] = 0;
            end
            if (csn_v[i]) begin
                hicnt[i]++;
            end else begin
                if (prev_csn[i]) gap[i] = hicnt[i];
                hicnt[i] = 0;
            end
            if (busy_v[i] && rdy[i]) rdy_bad[i]++;
            prev_sclk[i] = sclk_v[i];
            prev_csn[i]  = csn_v[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_idle(input int i, input string tag);
        check(tag, {25'h0, rdy[i], csn_v[i], sclk_v[i], mosi_v[i], busy_v[i], done_v[i], bv_v[i]},
              32'b1100000);
    endtask

    task automatic snap(input int i);
        s_cs   = cs_low[i];
        s_bv   = bvc[i];
        s_done = donec[i];
        s_rise = rises[i];
    endtask

    task automatic wait_done(input int i, input string tag);
        bit seen = 1'b0;
        int n    = 0;
        while (!seen && n < 400) begin
            tick();
            n++;
            if (done_v[i]) seen = 1'b1;
        end
        check({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        if (seen) check({tag, "_csn_at_done"}, {31'h0, csn_v[i]}, 32'h1);
    endtask

    task automatic send(input int i, input logic [15:0] w, input string tag);
        din[i] = w;
        vld[i] = 1'b1;
        tick();
        vld[i] = 1'b0;
        check({tag, "_cs_latency"}, {31'h0, csn_v[i]}, 32'h0);
        wait_done(i, tag);
        tick();
    endtask

    task automatic frame_chk(input int i, input string tag, input int ecs, input int ebv,
                             input int edone, input logic [31:0] word, input int w);
        logic [31:0] m;
        m = (32'h1 << w) - 32'h1;
        check({tag, "_cs_low"}, cs_low[i] - s_cs, ecs);
        check({tag, "_bit_valid"}, bvc[i] - s_bv, ebv);
        check({tag, "_done_cnt"}, donec[i] - s_done, edone);
        check({tag, "_sclk_rises"}, rises[i] - s_rise, ebv);
        check({tag, "_rx_word"}, rx[i] & m, word);
        check({tag, "_mosi_at_rise"}, rbits[i] & m, word);
    endtask

    initial begin
        int d0;
        int nbv;

        // Reset state, asserted asynchronously.
        #3;
        for (int i = 0; i < 3; i++) chk_idle(i, "reset_idle");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) chk_idle(i, "post_reset_idle");

        // T1: basic frame.
        snap(0);
        send(0, 16'h2C5, "t1");
        frame_chk(0, "t1", 42, 10, 1, 32'h2C5, 10);

        // T2: back-to-back with valid held high.
        snap(0);
        din[0] = 16'h3FF;
        vld[0] = 1'b1;
        tick();
        din[0] = 16'h000;
        wait_done(0, "t2a");
        tick();
        tick();
        vld[0] = 1'b0;
        check("t2_second_busy", {31'h0, busy_v[0]}, 32'h1);
        wait_done(0, "t2b");
        tick();
        check("t2_cs_low", cs_low[0] - s_cs, 84);
        check("t2_bit_valid", bvc[0] - s_bv, 20);
        check("t2_done_cnt", donec[0] - s_done, 2);
        check("t2_gap", gap[0], 2);
        check("t2_rx", rx[0] & 32'hFFFFF, {12'h0, 10'h3FF, 10'h000});
        check("t2_ready_in_frame", rdy_bad[0], 0);

        // T3: valid and data_in disturbed mid-frame.
        snap(0);
        din[0] = 16'h2C5;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        din[0] = 16'h155;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        din[0] = 16'h0AA;
        wait_done(0, "t3");
        for (int k = 0; k < 30; k++) tick();
        frame_chk(0, "t3", 42, 10, 1, 32'h2C5, 10);

        // T4: reset after the 4th bit_valid, between clock edges.
        din[0] = 16'h2C5;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        nbv = 0;
        for (int k = 0; k < 200 && nbv < 4; k++) begin
            if (bv_v[0]) nbv++;
            if (nbv < 4) tick();
        end
        check("t4_reached_4th_bit", nbv, 4);
        d0 = donec[0];
        rst_n = 1'b0;
        #1;
        chk_idle(0, "t4_abort_idle");
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("t4_no_done", donec[0], d0);
        snap(0);
        send(0, 16'h2C5, "t4");
        frame_chk(0, "t4", 42, 10, 1, 32'h2C5, 10);

        // T5: CLK_DIV=1.
        snap(1);
        send(1, 16'h155, "t5");
        frame_chk(1, "t5", 21, 10, 1, 32'h155, 10);
        check("t5_sclk_high_len", maxhi[1], 1);

        // T6: WIDTH=2, CLK_DIV=3.
        snap(2);
        send(2, 16'h2, "t6");
        frame_chk(2, "t6", 15, 2, 1, 32'h2, 2);
        check("t6_sclk_high_len", maxhi[2], 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
